id_ex_stage: RTL

ID/EX pipeline register of the 5-stage ARMv8 (LEGv8) pipeline. It sits directly downstream of the register file. It captures rd1/rd2, the immediate, PC and decoded control for the EX stage. It also detects load-use hazards against the instruction currently in EX and injects bubbles while stalling IF/ID. Because the register file already forwards same-cycle writes, no WB-to-ID bypass is needed here.

---
 rtl/id_ex_stage.sv | 131 +++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble injection
// and saturating stall/flush event counters.
module id_ex_stage #(
    parameter int N     = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [N-1:0]     id_pc,
    input  logic [4:0]       id_ra1,
    input  logic [4:0]       id_ra2,
    input  logic [N-1:0]     id_rd1,
    input  logic [N-1:0]     id_rd2,
    input  logic [4:0]       id_rd,
    input  logic [N-1:0]     id_imm,
    input  logic [9:0]       id_ctrl,
    input  logic             flush,
    output logic             stall_if_id,
    output logic             ex_valid,
    output logic [N-1:0]     ex_pc,
    output logic [N-1:0]     ex_rd1,
    output logic [N-1:0]     ex_rd2,
    output logic [N-1:0]     ex_imm,
    output logic [4:0]       ex_ra1,
    output logic [4:0]       ex_ra2,
    output logic [4:0]       ex_rd,
    output logic [9:0]       ex_ctrl,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [4:0] XZR = 5'd31;

    logic             valid_q, valid_d;
    logic [N-1:0]     pc_q, pc_d;
    logic [N-1:0]     rd1_q, rd1_d;
    logic [N-1:0]     rd2_q, rd2_d;
    logic [N-1:0]     imm_q, imm_d;
    logic [4:0]       ra1_q, ra1_d;
    logic [4:0]       ra2_q, ra2_d;
    logic [4:0]       rd_q, rd_d;
    logic [9:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             hz;
    logic             bubble;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // The instruction in EX is a load whose (non-XZR) result the ID instruction reads
    assign hz = id_valid & valid_q & ctrl_q[5] & (rd_q != XZR) &
                ((rd_q == id_ra1) | (rd_q == id_ra2));

    // A resolving branch redirects upstream, so holding IF/ID would be wrong
    assign stall_if_id = hz & ~flush;
    assign bubble      = flush | hz;

    always_comb begin
        valid_d     = id_valid;
        pc_d        = id_pc;
        rd1_d       = id_rd1;
        rd2_d       = id_rd2;
        imm_d       = id_imm;
        ra1_d       = id_ra1;
        ra2_d       = id_ra2;
        rd_d        = id_rd;
        ctrl_d      = id_ctrl;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bubble) begin
            valid_d = 1'b0;
            pc_d    = '0;
            rd1_d   = '0;
            rd2_d   = '0;
            imm_d   = '0;
            ra1_d   = '0;
            ra2_d   = '0;
            rd_d    = '0;
            ctrl_d  = '0;
        end
        if (flush) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else if (hz) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            imm_q       <= '0;
            ra1_q       <= '0;
            ra2_q       <= '0;
            rd_q        <= '0;
            ctrl_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            imm_q       <= imm_d;
            ra1_q       <= ra1_d;
            ra2_q       <= ra2_d;
            rd_q        <= rd_d;
            ctrl_q      <= ctrl_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid  = valid_q;
    assign ex_pc     = pc_q;
    assign ex_rd1    = rd1_q;
    assign ex_rd2    = rd2_q;
    assign ex_imm    = imm_q;
    assign ex_ra1    = ra1_q;
    assign ex_ra2    = ra2_q;
    assign ex_rd     = rd_q;
    assign ex_ctrl   = ctrl_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
